// File: rtl/im_pkg.sv
// Shared instruction-memory definitions: geometry, loader state encoding.
// The fetch-side word index (PC[10:2]) uses the same IM_ADDR_W.
package im_pkg;

    localparam int unsigned IM_ADDR_W         = 9;
    localparam int unsigned IM_DEPTH          = 512;
    localparam int unsigned IM_BYTES_PER_WORD = 4;
    localparam int unsigned IM_BYTE_W         = 8;
    localparam int unsigned IM_WORD_W         = 32;
    localparam int unsigned IM_LEN_W          = IM_ADDR_W + 1;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'd0,
        LD_RECV  = 2'd1,
        LD_WRITE = 2'd2,
        LD_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/im_loader_if.sv
// Loader bus: load control, byte-stream handshake, IM write port and status.
//  master : load controller / byte source (drives start, len, abort, in_data, in_valid)
//  slave  : im_loader (drives in_ready, wr_*, busy, cpu_hold, done, err)
interface im_loader_if
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W = IM_ADDR_W
) ();

    logic                 start;
    logic [ADDR_W:0]      len;
    logic                 abort;
    logic [IM_BYTE_W-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [IM_WORD_W-1:0] wr_data;
    logic                 busy;
    logic                 cpu_hold;
    logic                 done;
    logic                 err;

    modport master (
        output start, len, abort, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
    );

    modport slave (
        input  start, len, abort, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err
    );

endinterface

// File: rtl/im_byte_packer.sv
// Little-endian byte-to-word packer.
//  clear_i      : restart at byte 0 (wins over load_i)
//  load_i       : store byte_i at the current byte slot
//  byte_i       : stream byte
//  word_full_c  : this load completes a word
//  word_c       : shift register with the current byte merged (complete word when word_full_c)
module im_byte_packer
    import im_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 load_i,
    input  logic [IM_BYTE_W-1:0] byte_i,
    output logic                 word_full_c,
    output logic [IM_WORD_W-1:0] word_c
);

    localparam int unsigned IDX_W = $clog2(IM_BYTES_PER_WORD);

    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [IM_WORD_W-1:0] shreg_q, shreg_d;

    // Next byte slot and shift-register contents
    always_comb begin
        byte_idx_d = byte_idx_q;
        shreg_d    = shreg_q;
        if (clear_i) begin
            byte_idx_d = '0;
        end else if (load_i) begin
            shreg_d[IM_BYTE_W*byte_idx_q +: IM_BYTE_W] = byte_i;
            byte_idx_d = byte_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_q <= '0;
            shreg_q    <= '0;
        end else begin
            byte_idx_q <= byte_idx_d;
            shreg_q    <= shreg_d;
        end
    end

    assign word_full_c = load_i && !clear_i
                      && (byte_idx_q == IDX_W'(IM_BYTES_PER_WORD - 1));
    // Merged view lets the loader register the finished word on the 4th byte
    assign word_c      = shreg_d;

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a byte stream into 32-bit words and writes
// them to consecutive IM word addresses from 0, holding the core while busy.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : im_loader_if.slave (start/len/abort, in_* handshake, wr_* port,
//               busy, cpu_hold, done, err) -- all outputs registered
module im_loader
    import im_pkg::*;
#(
    parameter int unsigned ADDR_W = IM_ADDR_W,
    parameter int unsigned DEPTH  = IM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    im_loader_if.slave  bus
);

    localparam int unsigned LEN_W = ADDR_W + 1;

    ld_state_e            state_q, state_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     word_cnt_q, word_cnt_d;
    logic                 in_ready_q, in_ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [IM_WORD_W-1:0] wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;

    logic                 pk_clear_c;
    logic                 pk_load_c;
    logic                 pk_full_c;
    logic [IM_WORD_W-1:0] pk_word_c;
    logic                 len_ok_c;

    im_byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (pk_clear_c),
        .load_i      (pk_load_c),
        .byte_i      (bus.in_data),
        .word_full_c (pk_full_c),
        .word_c      (pk_word_c)
    );

    assign len_ok_c = (bus.len != '0) && (bus.len <= LEN_W'(DEPTH));

    // Next state and registered-output values; abort beats start and handshake
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        in_ready_d = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        pk_clear_c = 1'b0;
        pk_load_c  = 1'b0;

        unique case (state_q)
            LD_IDLE: begin
                if (bus.start) begin
                    if (len_ok_c) begin
                        state_d    = LD_RECV;
                        len_d      = bus.len;
                        word_cnt_d = '0;
                        busy_d     = 1'b1;
                        in_ready_d = 1'b1;
                        pk_clear_c = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            LD_RECV: begin
                if (bus.abort) begin
                    state_d = LD_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                    if (bus.in_valid) begin
                        pk_load_c = 1'b1;
                        // 4th byte: register the whole word for the WRITE cycle
                        if (pk_full_c) begin
                            state_d    = LD_WRITE;
                            in_ready_d = 1'b0;
                            wr_en_d    = 1'b1;
                            wr_addr_d  = word_cnt_q[ADDR_W-1:0];
                            wr_data_d  = pk_word_c;
                        end
                    end
                end
            end

            LD_WRITE: begin
                if (bus.abort) begin
                    state_d = LD_IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    word_cnt_d = LEN_W'(word_cnt_q + 1'b1);
                    if (word_cnt_d == len_q) begin
                        state_d = LD_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = LD_RECV;
                        in_ready_d = 1'b1;
                        pk_clear_c = 1'b1;
                    end
                end
            end

            LD_DONE: begin
                state_d = LD_IDLE;
            end

            default: begin
                state_d = LD_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LD_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.busy     = busy_q;
    assign bus.cpu_hold = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: write monitor plus hand-computed expected words.
module tb_im_loader;
    import im_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    im_loader_if #(.ADDR_W(IM_ADDR_W)) bus ();

    im_loader #(.ADDR_W(IM_ADDR_W), .DEPTH(IM_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt = 0;
    logic [IM_ADDR_W-1:0] wq_addr[$];
    logic [31:0]          wq_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Write/pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                wq_addr.push_back(bus.wr_addr);
                wq_data.push_back(bus.wr_data);
                check("ready_in_write", 32'(bus.in_ready), 32'd0);
            end
            if (bus.done) done_cnt++;
            if (bus.err)  err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        done_cnt = 0;
        err_cnt  = 0;
    endtask

    task automatic start_load(input logic [IM_ADDR_W:0] n);
        bus.start = 1'b1;
        bus.len   = n;
        tick();
        bus.start = 1'b0;
        bus.len   = '1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h5A;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(bus.busy), 32'd0);
        tick();
        tick();
    endtask

    task automatic check_outs_zero(input string tag);
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        check({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
        check({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
        check({tag, "_wr_data"},  bus.wr_data,       32'd0);
        check({tag, "_busy"},     32'(bus.busy),     32'd0);
        check({tag, "_cpu_hold"}, 32'(bus.cpu_hold), 32'd0);
        check({tag, "_done"},     32'(bus.done),     32'd0);
        check({tag, "_err"},      32'(bus.err),      32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp2 [3];
        int unsigned nerr;
        logic [31:0] w;

        exp2[0] = 32'h13121110;
        exp2[1] = 32'h17161514;
        exp2[2] = 32'h1B1A1918;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.len      = '0;
        bus.abort    = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // Reset values
        #12;
        check_outs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: single word, in_valid held high
        clear_mon();
        start_load(10'd1);
        check("t1_busy",     32'(bus.busy),     32'd1);
        check("t1_cpu_hold", 32'(bus.cpu_hold), 32'd1);
        check("t1_in_ready", 32'(bus.in_ready), 32'd1);
        send_byte(8'hA0);
        send_byte(8'h02);
        send_byte(8'h40);
        send_byte(8'hF8);
        check("t1_wr_en",    32'(bus.wr_en),    32'd1);
        check("t1_wr_addr",  32'(bus.wr_addr),  32'd0);
        check("t1_wr_data",  bus.wr_data,       32'hF84002A0);
        check("t1_ready_wr", 32'(bus.in_ready), 32'd0);
        tick();
        check("t1_done",     32'(bus.done),     32'd1);
        check("t1_busy_dn",  32'(bus.busy),     32'd0);
        check("t1_hold_dn",  32'(bus.cpu_hold), 32'd0);
        check("t1_wr_en_dn", 32'(bus.wr_en),    32'd0);
        tick();
        check("t1_done_end", 32'(bus.done),     32'd0);
        check("t1_data_hold", bus.wr_data,      32'hF84002A0);
        check("t1_nwr",      wq_addr.size(),    32'd1);
        check("t1_ndone",    done_cnt,          32'd1);

        // 2: three words with random valid gaps
        clear_mon();
        start_load(10'd3);
        for (int i = 0; i < 12; i++) begin
            gap();
            send_byte(8'(8'h10 + i));
        end
        wait_idle();
        check("t2_nwr", wq_addr.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t2_addr%0d", i), 32'(wq_addr[i]), 32'(i));
            check($sformatf("t2_data%0d", i), wq_data[i], exp2[i]);
        end
        check("t2_ndone", done_cnt, 32'd1);
        check("t2_nerr",  err_cnt,  32'd0);

        // 3: illegal lengths, then full depth
        clear_mon();
        start_load(10'd0);
        check("t3_err0",  32'(bus.err),  32'd1);
        check("t3_busy0", 32'(bus.busy), 32'd0);
        tick();
        check("t3_err0_end", 32'(bus.err), 32'd0);
        start_load(10'd513);
        check("t3_err513",  32'(bus.err),  32'd1);
        check("t3_busy513", 32'(bus.busy), 32'd0);
        tick();
        tick();
        check("t3_bad_nwr",  wq_addr.size(), 32'd0);
        check("t3_bad_nerr", err_cnt,        32'd2);

        clear_mon();
        start_load(10'd512);
        for (int i = 0; i < 2048; i++) send_byte(8'(i));
        wait_idle();
        check("t3_nwr", wq_addr.size(), 32'd512);
        nerr = 0;
        for (int i = 0; i < 512; i++) begin
            w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
            if (wq_addr[i] !== 9'(i) || wq_data[i] !== w) nerr++;
        end
        check("t3_seq_errs",  nerr, 32'd0);
        check("t3_last_addr", 32'(wq_addr[511]), 32'd511);
        check("t3_last_data", wq_data[511],      32'hFFFEFDFC);
        check("t3_ndone",     done_cnt,          32'd1);

        // 4: abort mid second word, then a fresh load
        clear_mon();
        start_load(10'd4);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h21 + i));
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("t4_err",      32'(bus.err),      32'd1);
        check("t4_busy",     32'(bus.busy),     32'd0);
        check("t4_hold",     32'(bus.cpu_hold), 32'd0);
        check("t4_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        tick();
        check("t4_nwr",   wq_addr.size(), 32'd1);
        check("t4_addr",  32'(wq_addr[0]), 32'd0);
        check("t4_data",  wq_data[0],     32'h24232221);
        check("t4_ndone", done_cnt,       32'd0);
        check("t4_nerr",  err_cnt,        32'd1);

        clear_mon();
        start_load(10'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h31 + i));
        wait_idle();
        check("t4b_nwr",  wq_addr.size(), 32'd1);
        check("t4b_addr", 32'(wq_addr[0]), 32'd0);
        check("t4b_data", wq_data[0],     32'h34333231);

        // 5: asynchronous reset mid-word
        clear_mon();
        start_load(10'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #3;
        rst_n = 1'b0;
        #1;
        check_outs_zero("t5_rst");
        @(negedge clk);
        rst_n = 1'b1;
        bus.in_data  = 8'hCC;
        bus.in_valid = 1'b1;
        repeat (8) tick();
        bus.in_valid = 1'b0;
        check("t5_nwr",   wq_addr.size(),    32'd0);
        check("t5_busy",  32'(bus.busy),     32'd0);
        check("t5_ready", 32'(bus.in_ready), 32'd0);
        clear_mon();
        start_load(10'd1);
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
        wait_idle();
        check("t5b_nwr",  wq_addr.size(), 32'd1);
        check("t5b_data", wq_data[0],     32'h04030201);

        // 6: start while busy is ignored
        clear_mon();
        start_load(10'd2);
        send_byte(8'h41);
        send_byte(8'h42);
        bus.start = 1'b1;
        bus.len   = 10'd1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'(8'h43 + i));
        wait_idle();
        check("t6_nwr",   wq_addr.size(),  32'd2);
        check("t6_addr0", 32'(wq_addr[0]), 32'd0);
        check("t6_data0", wq_data[0],      32'h44434241);
        check("t6_addr1", 32'(wq_addr[1]), 32'd1);
        check("t6_data1", wq_data[1],      32'h48474645);
        check("t6_ndone", done_cnt,        32'd1);
        check("t6_nerr",  err_cnt,         32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
